cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter PCW, default 10: program-counter width.
REQ-002 SHALL have parameter IW, default 8: instruction width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level sampled in IDLE/HALTED; begins execution from pc=0.
REQ-006 imem_data  input  IW  instruction word at imem_addr, valid combinationally.
REQ-007 imem_addr  output  PCW  current pc.
REQ-008 inst_reg  output  IW  latched instruction; drives the decoder input.
REQ-009 branch_cond  input  1  ALU comparison result for BLT/BNE, valid in EXEC.
REQ-010 branch_target  input  PCW  target pc, valid in EXEC.
REQ-011 mem_req  output  1  data-memory request, held until accepted.
REQ-012 mem_we  output  1  1 = store (SW/ASW), 0 = load (LW/ALW); valid while mem_req=1.
REQ-013 mem_ready  input  1  memory accepts/completes the current request this cycle.
REQ-014 reg_we  output  1  one-cycle register-file write strobe, asserted only in WB.
REQ-015 alu_en  output  1  asserted only in EXEC.
REQ-016 halted  output  1  high in HALTED state.
REQ-017 instr_count  output  16  retired-instruction count, saturating at 16'hFFFF.

Function
REQ-018 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM, WB and HALTED.
REQ-019 IDLE/HALTED: start=1 -> FETCH, with pc and instr_count cleared to 0.
REQ-020 FETCH: inst_reg <= imem_data; -> DECODE.
REQ-021 DECODE: inst_reg == 8'b01110000 (HALT) -> HALTED; otherwise -> EXEC.
REQ-022 EXEC, IMME (10xxxxxx) or R-type (all remaining encodings) -> WB.
REQ-023 EXEC, BLT (110xxxxx) or BNE (111xxxxx): pc <= branch_cond ? branch_target : pc+1; retire; -> FETCH.
REQ-024 EXEC, LW (01101xxx), SW (01100xxx), ALW (0111110x) or ASW (011111xx other than ALW) -> MEM; ALW takes priority over ASW.
REQ-025 MEM: mem_req=1; stay in MEM while mem_ready=0; when mem_ready=1, store -> pc+1, retire, FETCH; load -> WB.
REQ-026 WB: reg_we=1; pc <= pc+1; retire; -> FETCH.
REQ-027 Latency: ALU/IMME 4 cycles; branch 3 cycles; store 4+N cycles; load 5+N cycles, where N = number of mem_ready=0 cycles spent in MEM.
REQ-028 pc+1 SHALL wrap from 2^PCW-1 to 0 without a flag.
REQ-029 Retire SHALL increment instr_count by 1; once at 16'hFFFF it holds. HALT SHALL NOT count as retired.
REQ-030 start SHALL be ignored in FETCH, DECODE, EXEC, MEM and WB.
REQ-031 mem_ready outside MEM SHALL be ignored.
REQ-032 mem_we and mem_req SHALL remain stable throughout MEM.
REQ-033 branch_target SHALL be taken verbatim, truncated to PCW bits.

Reset
REQ-034 rst_n=0 SHALL immediately force: state=IDLE, pc=0, inst_reg=0, instr_count=0, and mem_req, mem_we, reg_we, alu_en, halted all 0.
REQ-035 Reset mid-MEM SHALL drop the request with no completion; the next start restarts at pc=0.

Structure
REQ-036 A shared package cpu_pkg SHALL hold the state enum, an opcode-class enum (IMME, BLT, BNE, LW, SW, ALW, ASW, HALT, RTYPE) and the HALT encoding constant.
REQ-037 One sub-module, op_classify, SHALL map inst_reg to the opcode class combinationally. The existing decoder stays external and is driven by inst_reg.

Verification
REQ-038 Reset release, then start=1 with program {8'h80, 8'h70} -> IMME retires in 4 cycles (reg_we pulses once); halted=1 at cycle 7; instr_count=1.
REQ-039 BNE 8'hE0 with branch_cond=1 and branch_target=10'h005 -> imem_addr=5 in the FETCH 3 cycles after entry; with branch_cond=0 -> imem_addr=pc+1.
REQ-040 LW 8'h68 with mem_ready held low 3 cycles -> mem_req high for 4 cycles, mem_we=0, then reg_we pulses; total 8 cycles.
REQ-041 ASW 8'h7E with mem_ready=1 immediately -> mem_we=1, a single MEM cycle, no reg_we, pc+1.
REQ-042 pc=10'h3FF executing an R-type instruction -> next fetch at pc=0.
REQ-043 rst_n asserted during a MEM stall -> mem_req drops the same instant, state IDLE; start toggled during EXEC -> no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencer.
package cpu_pkg;

  localparam int unsigned OPC_W = 8;
  localparam logic [OPC_W-1:0] HALT_ENC = 8'b0111_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALTED
  } state_e;

  typedef enum logic [3:0] {
    OP_IMME,
    OP_BLT,
    OP_BNE,
    OP_LW,
    OP_SW,
    OP_ALW,
    OP_ASW,
    OP_HALT,
    OP_RTYPE
  } op_class_e;

  function automatic logic is_mem_op(input op_class_e c);
    return (c == OP_LW) || (c == OP_SW) || (c == OP_ALW) || (c == OP_ASW);
  endfunction

  function automatic logic is_store_op(input op_class_e c);
    return (c == OP_SW) || (c == OP_ASW);
  endfunction

endpackage

// File: rtl/op_classify.sv
// Combinational opcode-class lookup on the top byte of the latched instruction.
module op_classify
  import cpu_pkg::*;
#(
  parameter int unsigned IW = 8
) (
  input  logic [IW-1:0] inst_i,
  output op_class_e     op_class_c_o
);

  logic [OPC_W-1:0] opc;

  assign opc = inst_i[IW-1 -: OPC_W];

  // Case order matters: ALW must win over the wider ASW pattern.
  always_comb begin
    op_class_c_o = OP_RTYPE;
    if (opc == HALT_ENC) begin
      op_class_c_o = OP_HALT;
    end else begin
      casez (opc)
        8'b10??????: op_class_c_o = OP_IMME;
        8'b110?????: op_class_c_o = OP_BLT;
        8'b111?????: op_class_c_o = OP_BNE;
        8'b01101???: op_class_c_o = OP_LW;
        8'b01100???: op_class_c_o = OP_SW;
        8'b0111110?: op_class_c_o = OP_ALW;
        8'b011111??: op_class_c_o = OP_ASW;
        default:     op_class_c_o = OP_RTYPE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback sequencer with retired-instruction counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PCW = 10,
  parameter int unsigned IW  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [IW-1:0]  imem_data_i,
  output logic [PCW-1:0] imem_addr_o,
  output logic [IW-1:0]  inst_reg_o,
  input  logic           branch_cond_i,
  input  logic [PCW-1:0] branch_target_i,
  output logic           mem_req_o,
  output logic           mem_we_o,
  input  logic           mem_ready_i,
  output logic           reg_we_o,
  output logic           alu_en_o,
  output logic           halted_o,
  output logic [15:0]    instr_count_o
);

  localparam int unsigned CNTW = 16;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_e          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d, pc_inc;
  logic [IW-1:0]   inst_q, inst_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic            reg_we_q, reg_we_d;
  logic            alu_en_q, alu_en_d;
  logic            halted_q, halted_d;
  op_class_e       op_class;

  op_classify #(.IW(IW)) u_op_classify (
    .inst_i       (inst_q),
    .op_class_c_o (op_class)
  );

  assign pc_inc  = pc_q + PCW'(1);
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      inst_q    <= '0;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      reg_we_q  <= 1'b0;
      alu_en_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      cnt_q     <= cnt_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      reg_we_q  <= reg_we_d;
      alu_en_q  <= alu_en_d;
      halted_q  <= halted_d;
    end
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start_i) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        inst_d  = imem_data_i;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = (op_class == OP_HALT) ? ST_HALTED : ST_EXEC;
      end
      ST_EXEC: begin
        if ((op_class == OP_BLT) || (op_class == OP_BNE)) begin
          pc_d    = branch_cond_i ? branch_target_i : pc_inc;
          cnt_d   = cnt_inc;
          state_d = ST_FETCH;
        end else if (is_mem_op(op_class)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready_i) begin
          if (is_store_op(op_class)) begin
            pc_d    = pc_inc;
            cnt_d   = cnt_inc;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        pc_d    = pc_inc;
        cnt_d   = cnt_inc;
        state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    mem_req_d = (state_d == ST_MEM);
    mem_we_d  = (state_d == ST_MEM) && is_store_op(op_class);
    reg_we_d  = (state_d == ST_WB);
    alu_en_d  = (state_d == ST_EXEC);
    halted_d  = (state_d == ST_HALTED);
  end

  assign imem_addr_o   = pc_q;
  assign inst_reg_o    = inst_q;
  assign instr_count_o = cnt_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign reg_we_o      = reg_we_q;
  assign alu_en_o      = alu_en_q;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench: directed programs plus a random program against a latency/PC model.
module tb_cpu_sequencer;

  localparam int unsigned PCW = 10;
  localparam int unsigned IW  = 8;
  localparam int DEPTH  = 1 << PCW;
  localparam int K_ALU  = 0;
  localparam int K_BR   = 1;
  localparam int K_ST   = 2;
  localparam int K_LD   = 3;
  localparam int K_HALT = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_i;
  logic [IW-1:0]  imem_data_i;
  logic [PCW-1:0] imem_addr_o;
  logic [IW-1:0]  inst_reg_o;
  logic           branch_cond_i;
  logic [PCW-1:0] branch_target_i;
  logic           mem_req_o;
  logic           mem_we_o;
  logic           mem_ready_i;
  logic           reg_we_o;
  logic           alu_en_o;
  logic           halted_o;
  logic [15:0]    instr_count_o;

  logic [IW-1:0]  imem [DEPTH];
  int n_cmp  = 0;
  int n_fail = 0;
  int m_pc;
  int m_cnt;

  cpu_sequencer #(.PCW(PCW), .IW(IW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .imem_data_i     (imem_data_i),
    .imem_addr_o     (imem_addr_o),
    .inst_reg_o      (inst_reg_o),
    .branch_cond_i   (branch_cond_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_we_o        (mem_we_o),
    .mem_ready_i     (mem_ready_i),
    .reg_we_o        (reg_we_o),
    .alu_en_o        (alu_en_o),
    .halted_o        (halted_o),
    .instr_count_o   (instr_count_o)
  );

  always #5 clk = ~clk;

  assign imem_data_i = imem[imem_addr_o];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction kind from the opcode byte, expressed as numeric ranges.
  function automatic int classify(input int b);
    if (b == 'h70) return K_HALT;
    if (b >= 'hC0) return K_BR;
    if (b >= 'h80) return K_ALU;
    if (b >= 'h7C && b <= 'h7D) return K_LD;
    if (b >= 'h7E) return K_ST;
    if (b >= 'h68 && b <= 'h6F) return K_LD;
    if (b >= 'h60 && b <= 'h67) return K_ST;
    return K_ALU;
  endfunction

  // Caller is at an IDLE/HALTED sample point; leaves the bench at the first FETCH.
  task automatic do_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    m_pc  = 0;
    m_cnt = 0;
  endtask

  // Runs one instruction from its FETCH cycle, checking every cycle's strobes.
  task automatic run_instr(input logic cond, input int tgt, input int stall);
    int  b, kind, len;
    logic memc, exp_we;
    b    = int'(imem[m_pc]);
    kind = classify(b);
    case (kind)
      K_ALU:   len = 4;
      K_BR:    len = 3;
      K_ST:    len = 4 + stall;
      K_LD:    len = 5 + stall;
      default: len = 2;
    endcase
    for (int k = 0; k < len; k++) begin
      if (k == 0) begin
        check("fetch_pc", 32'(imem_addr_o), 32'(m_pc));
        check("count", 32'(instr_count_o), 32'(m_cnt));
      end
      if (k == 1) check("inst_reg", 32'(inst_reg_o), 32'(b));
      memc   = ((kind == K_ST) || (kind == K_LD)) && (k >= 3) && (k <= 3 + stall);
      exp_we = ((kind == K_ALU) && (k == 3)) || ((kind == K_LD) && (k == 4 + stall));
      check("alu_en", 32'(alu_en_o), 32'(k == 2));
      check("mem_req", 32'(mem_req_o), 32'(memc));
      if (memc) check("mem_we", 32'(mem_we_o), 32'(kind == K_ST));
      check("reg_we", 32'(reg_we_o), 32'(exp_we));
      check("halted", 32'(halted_o), 32'(0));
      start_i         = 1'($urandom_range(0, 1));
      mem_ready_i     = memc ? (k == 3 + stall) : 1'($urandom_range(0, 1));
      branch_cond_i   = (k == 2) ? cond : 1'($urandom_range(0, 1));
      branch_target_i = (k == 2) ? PCW'(tgt) : PCW'($urandom);
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    if (kind == K_HALT) begin
      check("halt_flag", 32'(halted_o), 32'(1));
      check("halt_pc", 32'(imem_addr_o), 32'(m_pc));
      check("halt_count", 32'(instr_count_o), 32'(m_cnt));
    end else begin
      m_pc  = ((kind == K_BR) && cond) ? (tgt % DEPTH) : ((m_pc + 1) % DEPTH);
      m_cnt = (m_cnt == 'hFFFF) ? m_cnt : m_cnt + 1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    branch_cond_i = 1'b0;
    branch_target_i = '0;
    mem_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) imem[i] = '0;
    m_pc = 0;
    m_cnt = 0;

    #2;
    check("rst_addr", 32'(imem_addr_o), 32'(0));
    check("rst_ir", 32'(inst_reg_o), 32'(0));
    check("rst_count", 32'(instr_count_o), 32'(0));
    check("rst_strobes", 32'({mem_req_o, mem_we_o, reg_we_o, alu_en_o, halted_o}), 32'(0));

    // IMME then HALT.
    imem[0] = 8'h80;
    imem[1] = 8'h70;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_halted", 32'(halted_o), 32'(0));
    do_start();
    run_instr(1'b0, 0, 0);
    run_instr(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("halt_hold", 32'(halted_o), 32'(1));
      check("halt_hold_count", 32'(instr_count_o), 32'(1));
    end

    // BNE taken to 5, then not taken to 6, then halt.
    imem[0] = 8'hE0;
    imem[5] = 8'hE0;
    imem[6] = 8'h70;
    do_start();
    run_instr(1'b1, 'h005, 0);
    run_instr(1'b0, 'h02A, 0);
    run_instr(1'b0, 0, 0);

    // LW with 3 stalls, ASW, BLT to the top of memory, R-type wrapping to 0.
    imem[0]     = 8'h68;
    imem[1]     = 8'h7E;
    imem[2]     = 8'hC0;
    imem[DEPTH-1] = 8'h00;
    do_start();
    run_instr(1'b0, 0, 3);
    run_instr(1'b0, 0, 0);
    run_instr(1'b1, DEPTH - 1, 0);
    run_instr(1'b0, 0, 0);

    // LW again at pc 0: reset while the request is stalled.
    check("wrap_pc", 32'(imem_addr_o), 32'(0));
    for (int k = 0; k < 4; k++) begin
      start_i = 1'($urandom_range(0, 1));
      mem_ready_i = 1'b0;
      @(posedge clk); #1;
    end
    check("stall_req", 32'(mem_req_o), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(mem_req_o), 32'(0));
    check("rst_mid_strobes", 32'({mem_we_o, reg_we_o, alu_en_o, halted_o}), 32'(0));
    check("rst_mid_count", 32'(instr_count_o), 32'(0));
    check("rst_mid_addr", 32'(imem_addr_o), 32'(0));
    start_i = 1'b0;
    mem_ready_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_req", 32'(mem_req_o), 32'(0));
    check("post_rst_count", 32'(instr_count_o), 32'(0));
    check("post_rst_ir", 32'(inst_reg_o), 32'(0));

    // Random program without HALT.
    for (int i = 0; i < DEPTH; i++) begin
      imem[i] = IW'($urandom);
      if (imem[i] == 8'h70) imem[i] = 8'h00;
    end
    do_start();
    for (int n = 0; n < 400; n++) begin
      run_instr(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                int'($urandom_range(0, 3)));
    end
    check("final_count", 32'(instr_count_o), 32'(m_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
